// File: rtl/axis_sa_transpose.sv
// Ping-pong corner-turn buffer: column beats from the systolic array in, row beats out.
// Optional macro AXIS_SA_TRANSPOSE_LAST_CHECK_EN enables the sticky s_last framing check.
module axis_sa_transpose #(
  parameter int R  = 2,
  parameter int C  = 2,
  parameter int WY = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic [R-1:0][WY-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [C-1:0][WY-1:0] m_data,
  output logic                 err_last
);

  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(C - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2
  } bank_st_e;

  bank_st_e st_q [2];
  bank_st_e st_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          s_ready_q, s_ready_d;
  logic [1:0][R-1:0][C-1:0][WY-1:0] mem_q, mem_d;

  logic          s_fire;
  logic          m_fire;
  logic [CW-1:0] wr_col;

  assign s_fire  = s_valid && s_ready_q;
  assign m_valid = (st_q[rd_ptr_q] == BANK_FULL);
  assign m_fire  = m_valid && m_ready;
  assign m_last  = m_valid && (row_cnt_q == ROW_LAST);
  assign m_data  = mem_q[rd_ptr_q][row_cnt_q];
  assign s_ready = s_ready_q;

  // Beats arrive last column first, so beat j lands in column C-1-j.
  assign wr_col = COL_LAST - col_cnt_q;

  always_comb begin
    st_d      = st_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    mem_d     = mem_q;

    if (s_fire) begin
      for (int r = 0; r < R; r++) begin
        mem_d[wr_ptr_q][r][wr_col] = s_data[r];
      end
      if (col_cnt_q == COL_LAST) begin
        st_d[wr_ptr_q] = BANK_FULL;
        col_cnt_d      = '0;
        wr_ptr_d       = ~wr_ptr_q;
      end else begin
        st_d[wr_ptr_q] = BANK_FILL;
        col_cnt_d      = col_cnt_q + 1'b1;
      end
    end

    if (m_fire) begin
      if (row_cnt_q == ROW_LAST) begin
        st_d[rd_ptr_q] = BANK_EMPTY;
        row_cnt_d      = '0;
        rd_ptr_d       = ~rd_ptr_q;
      end else begin
        row_cnt_d      = row_cnt_q + 1'b1;
      end
    end

    // Look ahead at the bank that will be the write target next cycle,
    // so a fill and a drain completing together leave no bubble.
    s_ready_d = (st_d[wr_ptr_d] != BANK_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]   <= BANK_EMPTY;
      st_q[1]   <= BANK_EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      s_ready_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef AXIS_SA_TRANSPOSE_LAST_CHECK_EN
  logic err_last_q, err_last_d;

  // Tile framing is by count; s_last is only cross-checked against it.
  always_comb begin
    err_last_d = err_last_q;
    if (s_fire && (s_last != (col_cnt_q == COL_LAST))) begin
      err_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_last_q <= 1'b0;
    end else begin
      err_last_q <= err_last_d;
    end
  end

  assign err_last = err_last_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign err_last      = 1'b0;
`endif

endmodule

// File: tb/tb_axis_sa_transpose.sv
// Directed and table-driven bench for axis_sa_transpose at R=2, C=2, WY=11.
module tb_axis_sa_transpose;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int WY = 11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic                 s_last;
  logic [R-1:0][WY-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic [C-1:0][WY-1:0] m_data;
  logic                 err_last;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  axis_sa_transpose #(.R(R), .C(C), .WY(WY)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data),
    .err_last(err_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] in0;
    logic [21:0] in1;
    logic [21:0] exp0;
    logic [21:0] exp1;
  } vec_t;

  vec_t vecs [5];

  logic [21:0] sbeat [$];
  logic [22:0] sexp  [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Starts #1 after a posedge; returns #1 after the posedge that accepted the beat.
  task automatic send_beat(input logic [21:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic apply_tile(input string name, input logic [21:0] in0, input logic l0,
                            input logic [21:0] in1, input logic l1,
                            input logic [21:0] exp0, input logic [21:0] exp1);
    send_beat(in0, l0);
    send_beat(in1, l1);
    @(negedge clk);
    chk({name, "_row0"}, {m_valid, m_last, m_data}, {1'b1, 1'b0, exp0});
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_row1"}, {m_valid, m_last, m_data}, {1'b1, 1'b1, exp1});
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_idle"}, {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Queue one tile given as Y[r][c]: beat j carries column C-1-j, rows go out row-major.
  task automatic push_tile(input logic [10:0] y00, input logic [10:0] y01,
                           input logic [10:0] y10, input logic [10:0] y11);
    sbeat.push_back({y11, y01});
    sbeat.push_back({y10, y00});
    sexp.push_back({1'b0, y01, y00});
    sexp.push_back({1'b1, y11, y10});
  endtask

  task automatic run_stream(input int hold, output int cycles, output int stalls);
    int k = 0;
    int o = 0;
    int nb = sbeat.size();
    int no = sexp.size();
    int unstable = 0;
    logic [21:0] prev = '0;
    logic prev_held = 1'b0;
    cycles = 0;
    stalls = 0;
    while ((k < nb || o < no) && cycles < 300) begin
      m_ready = (cycles >= hold);
      s_valid = (k < nb);
      s_data  = sbeat[(k < nb) ? k : nb - 1];
      s_last  = (k % 2 == 1);
      @(negedge clk);
      if (cycles == hold - 1) begin
        chk("bp_accepted", 32'(k), 32'd4);
        chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      end
      if (s_valid && !s_ready && m_ready) stalls++;
      if (m_valid && !m_ready) begin
        if (prev_held && m_data !== prev) unstable++;
        prev = m_data;
        prev_held = 1'b1;
      end else begin
        prev_held = 1'b0;
      end
      if (m_valid && m_ready && o < no) begin
        chk("stream_beat", {m_last, m_data}, sexp[o]);
        o++;
      end
      if (s_valid && s_ready) k++;
      @(posedge clk); #1;
      cycles++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("stream_outputs", 32'(o), 32'(no));
    if (hold > 0) chk("bp_stable", 32'(unstable), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, stl;
    logic exp_err;
`ifdef AXIS_SA_TRANSPOSE_LAST_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    vecs[0] = '{ {11'd4, 11'd3}, {11'd2, 11'd1}, {11'd3, 11'd1}, {11'd4, 11'd2} };
    vecs[1] = '{ {11'(-1024), 11'd1023}, {11'(-1), 11'd0},
                 {11'd1023, 11'd0}, {11'(-1024), 11'(-1)} };
    vecs[2] = '{ {11'd10, 11'd20}, {11'd30, 11'd40}, {11'd20, 11'd40}, {11'd10, 11'd30} };
    vecs[3] = '{ {11'd1023, 11'(-1024)}, {11'(-1024), 11'd1023},
                 {11'(-1024), 11'd1023}, {11'd1023, 11'(-1024)} };
    vecs[4] = '{ {11'd5, 11'd6}, {11'd7, 11'd8}, {11'd6, 11'd8}, {11'd5, 11'd7} };

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {28'd0, s_ready, m_valid, m_last, err_last}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1;

    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply_tile($sformatf("vec%0d", i), vecs[i].in0, 1'b0, vecs[i].in1, 1'b1,
                 vecs[i].exp0, vecs[i].exp1);
    end
    chk("err_clean", {31'd0, err_last}, 32'd0);

    // s_last on beat 0 and missing on beat 1; framing still by count.
    apply_tile("mislast", {11'd9, 11'd3}, 1'b1, {11'd12, 11'd100}, 1'b0,
               {11'd3, 11'd100}, {11'd9, 11'd12});
    chk("err_set", {31'd0, err_last}, {31'd0, exp_err});
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", {31'd0, err_last}, {31'd0, exp_err});

    sbeat.delete(); sexp.delete();
    for (int t = 0; t < 50; t++) begin
      push_tile(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom));
    end
    run_stream(0, cyc, stl);
    chk("rand_no_stall", 32'(stl), 32'd0);
    chk("rand_cycles", 32'(cyc), 32'd102);

    sbeat.delete(); sexp.delete();
    push_tile(11'd4, 11'd2, 11'd3, 11'd1);
    push_tile(11'd14, 11'd12, 11'd13, 11'd11);
    push_tile(11'(-8), 11'(-6), 11'(-7), 11'(-5));
    run_stream(10, cyc, stl);
    chk("bp_err_held", {31'd0, err_last}, {31'd0, exp_err});

    m_ready = 1'b1;
    send_beat({11'd99, 11'd98}, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_state", {29'd0, s_ready, m_valid, err_last}, 32'h4);
    @(posedge clk); #1;
    sbeat.delete(); sexp.delete();
    sbeat.push_back({11'd8, 11'd7});
    sbeat.push_back({11'd6, 11'd5});
    sexp.push_back({1'b0, 11'd7, 11'd5});
    sexp.push_back({1'b1, 11'd8, 11'd6});
    run_stream(0, cyc, stl);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_stale", {31'd0, m_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
